fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage core. Owns the PC, drives the synchronous-read instruction memory, and presents a PC/instruction pair to decode. It is the consumer of the load-use freeze request from the hazard protection unit and of the branch/jump redirect from EX. A hold buffer keeps the ID instruction stable across freezes despite the 1-cycle memory read latency.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction presented to ID when the IF/ID slot is a bubble (addi x0,x0,0)
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- freeze_i  input  1  load-use stall request from hazard protection unit
- redirect_i  input  1  taken branch/jump resolved in EX
- redirect_pc_i  input  32  target address; bits [1:0] forced to 0
- imem_addr_o  output  32  instruction memory address (= pc_q)
- imem_rdata_i  input  32  instruction memory data; returns mem[addr] one cycle after addr
- pc_id_o  output  32  PC of instruction in ID
- pc_plus4_id_o  output  32  pc_id_o + 4, modulo 2^32
- instr_id_o  output  32  instruction in ID
- valid_id_o  output  1  ID slot holds a real instruction
- stall_count_o  output  32  cycles frozen, saturating
- flush_count_o  output  32  redirects taken, saturating

## Operation
- State: pc_q, pc_id_q, valid_id_q, instr_hold_q, hold_valid_q, two counters.
- instr_id_o = !valid_id_q ? NOP_INSTR : (hold_valid_q ? instr_hold_q : imem_rdata_i).
- Per-cycle action, priority order:
  - redirect_i: pc_q <= {redirect_pc_i[31:2],2'b00}; valid_id_q <= 0; hold_valid_q <= 0; flush_count +1. freeze_i ignored, stall_count unchanged.
  - freeze_i: pc_q, pc_id_q, valid_id_q hold; if !hold_valid_q then instr_hold_q <= imem_rdata_i, hold_valid_q <= 1; stall_count +1.
  - else (advance): pc_id_q <= pc_q; pc_q <= pc_q + 4; valid_id_q <= 1; hold_valid_q <= 0.
- ID/EX flush on redirect belongs to the control path; this block flushes only IF/ID.
- PC arithmetic 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset (asynchronous assert, any cycle including mid-freeze): pc_q = RESET_PC, pc_id_q = 0, valid_id_q = 0, hold_valid_q = 0, instr_hold_q = 0, counters = 0. Outputs: imem_addr_o = RESET_PC, valid_id_o = 0, instr_id_o = NOP_INSTR, pc_plus4_id_o = 4.
- First edge after release: ID = RESET_PC, valid, instr = mem[RESET_PC].
- Freeze latency 0: the freeze cycle's ID contents persist in the next cycle; hold buffer captures on the first freeze edge only, so multi-cycle freezes keep the original instruction.
- Release: first non-freeze cycle advances; next cycle imem_rdata_i = mem[new pc_id] and hold buffer is bypassed.
- Redirect: cycle t+1 ID bubble (valid 0) with imem_addr_o = target; t+2 ID = target, valid 1.
- freeze_i while valid_id_q = 0: bubble held; hold buffer content unused.

## Test plan
- Reset, RESET_PC=0x100, no stalls -> imem_addr_o 0x100,0x104,0x108; ID valid from cycle 1 with pc_id 0x100, 0x104, instr = mem[pc].
- Freeze 3 cycles with pc_id=0x108 -> pc_id_o=0x108 and instr_id_o=mem[0x108] for 4 cycles, imem_addr_o held at 0x10C, stall_count_o=3, then 0x10C in ID.
- Redirect to 0x2002 -> imem_addr_o=0x2000 next cycle, one bubble (valid 0, instr 0x13), then pc_id 0x2000; flush_count_o=1.
- Redirect and freeze asserted together -> redirect behaviour exactly as above, stall_count_o unchanged.
- Reset asserted mid-freeze (hold_valid set) -> all outputs at reset values immediately; after release fetch restarts at RESET_PC with hold buffer bypassed.
- Redirect to 0xFFFF_FFFC, no stalls -> ID shows 0xFFFF_FFFC then 0x0000_0000; pc_plus4_id_o = 0x0000_0000 for the first.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
//
// Owns the PC, drives a synchronous-read instruction memory (data returns one
// cycle after the address) and presents a PC/instruction pair to decode.
// A load-use freeze holds the IF/ID slot; a redirect from EX reloads the PC and
// turns the IF/ID slot into a bubble. Redirect wins over freeze.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   freeze_i       load-use stall request
//   redirect_i     taken branch/jump resolved in EX
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   imem_addr_o    instruction memory address (current fetch PC)
//   imem_rdata_i   instruction memory read data (mem[addr of previous cycle])
//   pc_id_o        PC of the instruction in ID
//   pc_plus4_id_o  pc_id_o + 4, modulo 2^32
//   instr_id_o     instruction in ID (NOP_INSTR when the slot is a bubble)
//   valid_id_o     ID slot holds a real instruction
//   stall_count_o  frozen cycles, saturating
//   flush_count_o  redirects taken, saturating

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        freeze_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_id_o,
    output logic [31:0] pc_plus4_id_o,
    output logic [31:0] instr_id_o,
    output logic        valid_id_o,
    output logic [31:0] stall_count_o,
    output logic [31:0] flush_count_o
);

    localparam logic [31:0] CountMax = 32'hFFFF_FFFF;

    logic [31:0] pc_q,          pc_d;
    logic [31:0] pc_id_q,       pc_id_d;
    logic        valid_id_q,    valid_id_d;
    logic [31:0] instr_hold_q,  instr_hold_d;
    logic        hold_valid_q,  hold_valid_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            pc_id_q       <= 32'h0;
            valid_id_q    <= 1'b0;
            instr_hold_q  <= 32'h0;
            hold_valid_q  <= 1'b0;
            stall_count_q <= 32'h0;
            flush_count_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            pc_id_q       <= pc_id_d;
            valid_id_q    <= valid_id_d;
            instr_hold_q  <= instr_hold_d;
            hold_valid_q  <= hold_valid_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: redirect > freeze > advance
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        pc_id_d       = pc_id_q;
        valid_id_d    = valid_id_q;
        instr_hold_d  = instr_hold_q;
        hold_valid_d  = hold_valid_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;

        if (redirect_i) begin
            // The instruction arriving from memory next cycle belongs to the
            // wrong path, so IF/ID becomes a bubble and any held copy is dropped.
            pc_d         = {redirect_pc_i[31:2], 2'b00};
            valid_id_d   = 1'b0;
            hold_valid_d = 1'b0;
            if (flush_count_q != CountMax) begin
                flush_count_d = flush_count_q + 32'd1;
            end
        end else if (freeze_i) begin
            // Memory keeps reading pc_q (the next instruction), so the ID
            // instruction must be captured on the first frozen edge only.
            if (!hold_valid_q) begin
                instr_hold_d = imem_rdata_i;
                hold_valid_d = 1'b1;
            end
            if (stall_count_q != CountMax) begin
                stall_count_d = stall_count_q + 32'd1;
            end
        end else begin
            pc_id_d      = pc_q;
            pc_d         = pc_q + 32'd4;
            valid_id_d   = 1'b1;
            hold_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_addr_o   = pc_q;
        pc_id_o       = pc_id_q;
        pc_plus4_id_o = pc_id_q + 32'd4;
        valid_id_o    = valid_id_q;
        stall_count_o = stall_count_q;
        flush_count_o = flush_count_q;
        if (!valid_id_q) begin
            instr_id_o = NOP_INSTR;
        end else if (hold_valid_q) begin
            instr_id_o = instr_hold_q;
        end else begin
            instr_id_o = imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        freeze;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] pc_plus4_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .freeze_i     (freeze),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .pc_id_o      (pc_id),
        .pc_plus4_id_o(pc_plus4_id),
        .instr_id_o   (instr_id),
        .valid_id_o   (valid_id),
        .stall_count_o(stall_count),
        .flush_count_o(flush_count)
    );

    always #5 clk = ~clk;

    // Memory contents: a simple address-derived pattern, distinct from NOP.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h5A00_0000 ^ a;
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) imem_rdata <= mem(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        frz;
        logic        rdr;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic [31:0] e_pc_id;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_stall;
        logic [31:0] e_flush;
    } vec_t;

    vec_t vecs[20];

    task automatic apply(input logic f, input logic r, input logic [31:0] rpc);
        freeze      = f;
        redirect    = r;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
        freeze      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
    endtask

    initial begin
        // inputs (freeze, redirect, target) -> outputs seen after the next edge
        vecs[0]  = '{0, 0, 32'h0,         32'h104,       32'h100,       1, mem(32'h100),  0, 0};
        vecs[1]  = '{0, 0, 32'h0,         32'h108,       32'h104,       1, mem(32'h104),  0, 0};
        vecs[2]  = '{0, 0, 32'h0,         32'h10C,       32'h108,       1, mem(32'h108),  0, 0};
        vecs[3]  = '{1, 0, 32'h0,         32'h10C,       32'h108,       1, mem(32'h108),  1, 0};
        vecs[4]  = '{1, 0, 32'h0,         32'h10C,       32'h108,       1, mem(32'h108),  2, 0};
        vecs[5]  = '{1, 0, 32'h0,         32'h10C,       32'h108,       1, mem(32'h108),  3, 0};
        vecs[6]  = '{0, 0, 32'h0,         32'h110,       32'h10C,       1, mem(32'h10C),  3, 0};
        vecs[7]  = '{0, 1, 32'h2002,      32'h2000,      32'h0,         0, NOP,           3, 1};
        vecs[8]  = '{0, 0, 32'h0,         32'h2004,      32'h2000,      1, mem(32'h2000), 3, 1};
        vecs[9]  = '{1, 1, 32'h3000,      32'h3000,      32'h0,         0, NOP,           3, 2};
        vecs[10] = '{0, 0, 32'h0,         32'h3004,      32'h3000,      1, mem(32'h3000), 3, 2};
        vecs[11] = '{1, 0, 32'h0,         32'h3004,      32'h3000,      1, mem(32'h3000), 4, 2};
        vecs[12] = '{1, 1, 32'h4001,      32'h4000,      32'h0,         0, NOP,           4, 3};
        vecs[13] = '{0, 0, 32'h0,         32'h4004,      32'h4000,      1, mem(32'h4000), 4, 3};
        vecs[14] = '{0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         0, NOP,           4, 4};
        vecs[15] = '{0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1, mem(32'hFFFF_FFFC), 4, 4};
        vecs[16] = '{0, 0, 32'h0,         32'h4,         32'h0,         1, mem(32'h0),    4, 4};
        vecs[17] = '{0, 1, 32'h500,       32'h500,       32'h0,         0, NOP,           4, 5};
        vecs[18] = '{1, 0, 32'h0,         32'h500,       32'h0,         0, NOP,           5, 5};
        vecs[19] = '{0, 0, 32'h0,         32'h504,       32'h500,       1, mem(32'h500),  5, 5};

        rst_ni      = 1'b0;
        freeze      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",   imem_addr,           RST_PC);
        check("rst_valid",  {31'h0, valid_id},   32'h0);
        check("rst_instr",  instr_id,            NOP);
        check("rst_pc_id",  pc_id,               32'h0);
        check("rst_plus4",  pc_plus4_id,         32'h4);
        check("rst_stall",  stall_count,         32'h0);
        check("rst_flush",  flush_count,         32'h0);
        rst_ni = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i].frz, vecs[i].rdr, vecs[i].rpc);
            check($sformatf("v%0d_addr", i),  imem_addr,          vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'h0, valid_id},  {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d_instr", i), instr_id,           vecs[i].e_instr);
            check($sformatf("v%0d_stall", i), stall_count,        vecs[i].e_stall);
            check($sformatf("v%0d_flush", i), flush_count,        vecs[i].e_flush);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc_id", i), pc_id,       vecs[i].e_pc_id);
                check($sformatf("v%0d_plus4", i), pc_plus4_id, vecs[i].e_pc_id + 32'd4);
            end
        end

        // Reset asserted in the middle of a freeze with the hold buffer loaded.
        apply(1'b0, 1'b0, 32'h0);   // ID = 0x504
        freeze = 1'b1;
        @(posedge clk);             // hold buffer captures mem(0x504)
        #3;
        rst_ni = 1'b0;
        #1;
        check("mrst_addr",  imem_addr,          RST_PC);
        check("mrst_valid", {31'h0, valid_id},  32'h0);
        check("mrst_instr", instr_id,           NOP);
        check("mrst_plus4", pc_plus4_id,        32'h4);
        check("mrst_stall", stall_count,        32'h0);
        check("mrst_flush", flush_count,        32'h0);
        @(posedge clk);
        #1;
        freeze = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check("post_pc_id", pc_id,              RST_PC);
        check("post_valid", {31'h0, valid_id},  32'h1);
        check("post_instr", instr_id,           mem(RST_PC));
        check("post_addr",  imem_addr,          RST_PC + 32'd4);
        apply(1'b1, 1'b0, 32'h0);
        check("post_frz_instr", instr_id,       mem(RST_PC));
        check("post_frz_stall", stall_count,    32'h1);
        apply(1'b0, 1'b0, 32'h0);
        check("post_adv_pc_id", pc_id,          RST_PC + 32'd4);
        check("post_adv_instr", instr_id,       mem(RST_PC + 32'd4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
